// File: rtl/ifu_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: memory map defaults,
// the NOP word, fetch FSM state encoding and the F/D pipeline register layout.
package ifu_fetch_pkg;

    localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
    localparam int unsigned DEF_IM_DEPTH = 4096;
    localparam int unsigned XLEN         = 32;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    // Fetch FSM states {RUN, HALT}
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_RUN  = 1'b0;
    localparam fetch_state_t ST_HALT = 1'b1;

    // F/D pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
        logic            valid;
        logic            exc;
    } fd_reg_t;

endpackage

// File: rtl/ifu_fetch_addr_check.sv
// Combinational fetch/data address check.
// Ports: pc (address under test), err (misaligned or outside
// [PC_RESET, PC_RESET + 4*IM_DEPTH)). All arithmetic is 32-bit unsigned.
module fetch_addr_check
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = DEF_PC_RESET,
    parameter int unsigned IM_DEPTH = DEF_IM_DEPTH
) (
    input  logic [31:0] pc,
    output logic        err
);

    localparam logic [31:0] SPAN = 32'(IM_DEPTH * 4);

    logic [31:0] offset;

    // Offset from the memory base; only meaningful when pc >= PC_RESET
    always_comb begin
        offset = pc - PC_RESET;
        err    = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (offset >= SPAN);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, drives im_addr into the combinational
// instruction memory and registers the returned word into the F/D register.
// Handles decode stall, branch/jump redirect (delay slot kept) and traps
// fetches from bad addresses by halting until a redirect arrives.
// Ports:
//   clk, reset         clock, async active-high reset
//   stall              freeze PC, F/D and state
//   redirect_valid/pc  taken branch/jump target from decode
//   im_addr/im_rdata   instruction memory request/response
//   d_instr, d_pc, d_pc8, d_valid, d_exc   F/D register to decode
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = DEF_PC_RESET,
    parameter int unsigned IM_DEPTH = DEF_IM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_exc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fd_reg_t      fd_q, fd_d;
    logic         pc_err;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_plus8;

    fetch_addr_check #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) u_check (
        .pc  (pc_q),
        .err (pc_err)
    );

    // Wrapping increments; a wrapped PC then fails the range check
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;

    // State, PC and F/D registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state logic; a stall holds everything and ignores redirect
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fd_d    = fd_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    fd_d.instr = pc_err ? NOP_WORD : im_rdata;
                    fd_d.pc    = pc_q;
                    fd_d.pc8   = pc_plus8;
                    fd_d.valid = 1'b1;
                    fd_d.exc   = pc_err;
                    // Redirect wins over a trap: the exc entry is still sent
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (pc_err) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_HALT: begin
                    fd_d.instr = NOP_WORD;
                    fd_d.pc    = pc_q;
                    fd_d.pc8   = pc_plus8;
                    fd_d.valid = 1'b0;
                    fd_d.exc   = 1'b0;
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign im_addr = pc_q;
    assign d_instr = fd_q.instr;
    assign d_pc    = fd_q.pc;
    assign d_pc8   = fd_q.pc8;
    assign d_valid = fd_q.valid;
    assign d_exc   = fd_q.exc;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit for the five-stage MIPS pipeline: holds the program counter, drives the fetch address into the combinational instruction memory, and registers the returned word into the F/D pipeline register. It is the requesting side of the instruction-memory interface and sits between the memory and the decode stage. It also handles decode-stage stall and branch/jump redirect, and traps fetches from misaligned or out-of-range addresses.

## Interface
- PC_RESET, 32'h0000_3000, first fetch address; base of instruction memory
- IM_DEPTH, 4096, instruction memory size in 32-bit words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  decode-stage stall; freezes PC and F/D register
- redirect_valid  in  1  branch/jump taken in decode stage this cycle
- redirect_pc  in  32  target address for the redirect
- im_addr  out  32  fetch address to instruction memory (= PC register)
- im_rdata  in  32  instruction word returned combinationally for im_addr
- d_instr  out  32  registered instruction to decode
- d_pc  out  32  registered PC of d_instr
- d_pc8  out  32  d_pc + 8 (link address)
- d_valid  out  1  d_instr is a real fetched instruction
- d_exc  out  1  fetch address error for d_pc

## Operation
- States: RUN, HALT.
- Address check, evaluated on PC every cycle: error if PC[1:0] != 0, PC < PC_RESET, or PC >= PC_RESET + 4*IM_DEPTH. The subtraction and comparison are 32-bit unsigned.
- RUN, no stall, no error:
  - F/D <= {im_rdata, PC, PC+8, valid=1, exc=0}.
  - PC <= redirect_valid ? redirect_pc : PC+4.
  - The word fetched in the same cycle as a redirect is the delay slot. It is kept, never flushed.
- RUN, no stall, error:
  - F/D <= {32'h0, PC, PC+8, valid=1, exc=1}.
  - PC holds; state -> HALT.
  - If redirect_valid is asserted in the same cycle, the redirect takes priority: PC <= redirect_pc, state stays RUN, and the exc entry is still written.
- HALT, no stall:
  - F/D <= bubble {32'h0, PC, PC+8, valid=0, exc=0}.
  - On redirect_valid: PC <= redirect_pc, state -> RUN. Otherwise PC holds.
- Any state with stall=1: PC, F/D and state all hold. redirect_valid is ignored; decode keeps the redirect asserted until the stall clears.
- PC+4 and PC+8 wrap modulo 2^32. A wrapped address fails the range check and is trapped as an error.
- redirect_pc is not checked on arrival. It is checked when it becomes PC.

## Timing
- Reset values (asynchronous): PC = PC_RESET, state = RUN, d_instr = 0, d_pc = 0, d_pc8 = 0, d_valid = 0, d_exc = 0.
- im_addr is combinational from the PC register, with zero delay. im_rdata must settle within the same cycle.
- Latency: the word at PC appears on d_* one clock after PC is presented.
- Redirect: target on im_addr the cycle after redirect_valid & !stall. The delay-slot word reaches d_* on that same edge.
- Reset mid-operation clears F/D immediately. The first fetch after deassertion is PC_RESET.
- Throughput: one instruction per cycle when not stalled.

## Structure
- Shared pipeline package holds:
  - PC_RESET and IM_DEPTH defaults
  - NOP word 32'h0
  - fetch state enum {RUN, HALT}
  - F/D register struct {instr, pc, pc8, valid, exc}
- One combinational sub-module, fetch_addr_check (pc in, err out, parameterised by PC_RESET/IM_DEPTH). It is reused by the data-memory side check.
- The PC register, F/D register and state register live in ifu_fetch.

## Test plan
- Reset, memory words 0x3000→A, 0x3004→B, 0x3008→C, 3 free cycles -> im_addr 3000,3004,3008,300C; d_instr A,B,C with d_pc 3000,3004,3008 and d_pc8 3008,300C,3010.
- stall=1 for 2 cycles while im_addr=0x3004 -> im_addr and d_* unchanged both cycles; fetch resumes at 0x3004→0x3008.
- redirect_valid with redirect_pc=0x3100 while im_addr=0x3008 -> next d_instr is the word at 0x3008 (delay slot); im_addr=0x3100 next cycle.
- redirect and stall together for 1 cycle, then redirect alone -> no redirect on the stalled edge; im_addr=0x3100 after the second edge.
- redirect_pc=0x3102 -> d_exc=1, d_pc=0x3102, d_instr=0; then d_valid=0 bubbles with im_addr held until redirect to 0x3000 resumes normal fetch.
- redirect_pc=0x2FFC, then 0x3000+4*IM_DEPTH -> each produces d_exc=1 and HALT; assert reset mid-HALT -> all outputs return to reset values and im_addr=0x3000.
